ricerca_pila: RTL and testbench

Stack unit with an associative search port. It holds up to DEPTH words of N bits with push/pop at the top. On request it scans the stored words from top to bottom, one per clock, against a key. It then reports whether a match was found and the position of the match. It is the consumer side of the word-equality comparison: it presents word pairs to an equality comparator and acts on its mismatch flag.

---
 rtl/ricerca_pila_pkg.sv | 15 +
 rtl/ricerca_pila_confronto.sv | 12 +
 rtl/ricerca_pila.sv | 163 ++++++++++++++++
 tb/tb_ricerca_pila.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ricerca_pila_pkg.sv
// Shared types and helpers for the ricerca_pila stack/search unit.
package ricerca_pila_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } stato_t;

  // Bits needed to address n distinct values; never less than 1.
  function automatic int unsigned larghezza(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ricerca_pila_confronto.sv
// confronto_parola: combinational N-bit equality, low when the two words match.
module confronto_parola #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] parola_a,
  input  logic [N-1:0] parola_b,
  output logic         diverso
);

  assign diverso = (parola_a != parola_b);

endmodule

// File: rtl/ricerca_pila.sv
// Stack of DEPTH N-bit words with a top-down associative search port.
// Optional occupancy output enabled by defining RICERCA_PILA_CONTEGGIO_EN.
module ricerca_pila
  import ricerca_pila_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push,
  input  logic                            pop,
  input  logic [N-1:0]                    dato_in,
  input  logic                            cerca,
  input  logic [N-1:0]                    chiave,
  output logic [N-1:0]                    dato_out,
  output logic                            vuota,
  output logic                            piena,
  output logic                            occupato,
  output logic                            fatto,
  output logic                            trovato,
  output logic [larghezza(DEPTH)-1:0]     indice,
  output logic                            errore
`ifdef RICERCA_PILA_CONTEGGIO_EN
  ,
  output logic [larghezza(DEPTH+1)-1:0]   conteggio
`endif
);

  localparam int unsigned PW = larghezza(DEPTH);
  localparam int unsigned SW = larghezza(DEPTH + 1);

  stato_t         state_q, state_d;
  logic [SW-1:0]  sp_q, sp_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [N-1:0]   chiave_q, chiave_d;
  logic           trovato_q, trovato_d;
  logic [PW-1:0]  indice_q, indice_d;
  logic           fatto_q, fatto_d;
  logic           errore_q, errore_d;

  logic [N-1:0]   mem_q [DEPTH];
  logic           wr_en;
  logic [PW-1:0]  wr_addr;
  logic [PW-1:0]  top_idx;
  logic           diverso;
  logic           vuota_c, piena_c;

  assign top_idx = PW'(sp_q - SW'(1));
  assign vuota_c = (sp_q == '0);
  assign piena_c = (sp_q == SW'(DEPTH));

  confronto_parola #(.N(N)) u_confronto (
    .parola_a (mem_q[ptr_q]),
    .parola_b (chiave_q),
    .diverso  (diverso)
  );

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    ptr_d     = ptr_q;
    chiave_d  = chiave_q;
    trovato_d = trovato_q;
    indice_d  = indice_q;
    // fatto is registered, so it trails the DONE state by one cycle
    fatto_d   = (state_q == ST_DONE);
    errore_d  = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = top_idx;
    unique case (state_q)
      ST_IDLE: begin
        if (cerca) begin
          chiave_d  = chiave;
          trovato_d = 1'b0;
          errore_d  = push | pop;
          if (vuota_c) begin
            indice_d = '0;
            state_d  = ST_DONE;
          end else begin
            ptr_d   = top_idx;
            state_d = ST_SCAN;
          end
        end else if (push && pop) begin
          // Replace top; on an empty stack this degenerates to a plain push
          wr_en = 1'b1;
          if (vuota_c) begin
            wr_addr = '0;
            sp_d    = sp_q + SW'(1);
          end
        end else if (push) begin
          if (piena_c) begin
            errore_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_addr = PW'(sp_q);
            sp_d    = sp_q + SW'(1);
          end
        end else if (pop) begin
          if (vuota_c) errore_d = 1'b1;
          else         sp_d     = sp_q - SW'(1);
        end
      end
      ST_SCAN: begin
        errore_d = push | pop | cerca;
        if (!diverso) begin
          trovato_d = 1'b1;
          indice_d  = ptr_q;
          state_d   = ST_DONE;
        end else if (ptr_q == '0) begin
          indice_d = '0;
          state_d  = ST_DONE;
        end else begin
          ptr_d = ptr_q - PW'(1);
        end
      end
      ST_DONE: begin
        errore_d = push | pop | cerca;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sp_q      <= '0;
      ptr_q     <= '0;
      chiave_q  <= '0;
      trovato_q <= 1'b0;
      indice_q  <= '0;
      fatto_q   <= 1'b0;
      errore_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      ptr_q     <= ptr_d;
      chiave_q  <= chiave_d;
      trovato_q <= trovato_d;
      indice_q  <= indice_d;
      fatto_q   <= fatto_d;
      errore_q  <= errore_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= dato_in;
  end

  assign dato_out = vuota_c ? '0 : mem_q[top_idx];
  assign vuota    = vuota_c;
  assign piena    = piena_c;
  assign occupato = (state_q != ST_IDLE);
  assign fatto    = fatto_q;
  assign trovato  = trovato_q;
  assign indice   = indice_q;
  assign errore   = errore_q;
`ifdef RICERCA_PILA_CONTEGGIO_EN
  assign conteggio = sp_q;
`endif

endmodule

// File: tb/tb_ricerca_pila.sv
// Randomized self-checking bench for ricerca_pila against a queue-based model.
module tb_ricerca_pila;

  localparam int unsigned N     = 16;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push, pop, cerca;
  logic [N-1:0]  dato_in, chiave;
  logic [N-1:0]  dato_out;
  logic          vuota, piena, occupato, fatto, trovato, errore;
  logic [2:0]    indice;
`ifdef RICERCA_PILA_CONTEGGIO_EN
  logic [3:0]    conteggio;
`endif

  ricerca_pila #(.N(N), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .dato_in  (dato_in),
    .cerca    (cerca),
    .chiave   (chiave),
    .dato_out (dato_out),
    .vuota    (vuota),
    .piena    (piena),
    .occupato (occupato),
    .fatto    (fatto),
    .trovato  (trovato),
    .indice   (indice),
    .errore   (errore)
`ifdef RICERCA_PILA_CONTEGGIO_EN
    ,
    .conteggio(conteggio)
`endif
  );

  always #5 clk = ~clk;

  logic [N-1:0] modello[$];
  int unsigned  n_cmp = 0;
  int unsigned  n_err = 0;

  task automatic verifica(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic controlla_stato(input string tag);
    logic [N-1:0] top;
    top = (modello.size() == 0) ? '0 : modello[modello.size()-1];
    verifica({tag, "_dato_out"}, 32'(dato_out), 32'(top));
    verifica({tag, "_vuota"},    32'(vuota),    32'(modello.size() == 0));
    verifica({tag, "_piena"},    32'(piena),    32'(modello.size() == DEPTH));
`ifdef RICERCA_PILA_CONTEGGIO_EN
    verifica({tag, "_conteggio"}, 32'(conteggio), 32'(modello.size()));
`endif
  endtask

  // One IDLE-state command; called at a negedge, returns at the next negedge.
  task automatic op(input logic p, input logic o, input logic [N-1:0] d);
    logic exp_err;
    exp_err = 1'b0;
    push = p; pop = o; dato_in = d;
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    if (p && o) begin
      if (modello.size() == 0) modello.push_back(d);
      else modello[modello.size()-1] = d;
    end else if (p) begin
      if (modello.size() == DEPTH) exp_err = 1'b1;
      else modello.push_back(d);
    end else if (o) begin
      if (modello.size() == 0) exp_err = 1'b1;
      else void'(modello.pop_back());
    end
    verifica("op_errore", 32'(errore), 32'(exp_err));
    controlla_stato("op");
  endtask

  task automatic ricerca(input logic [N-1:0] key, input logic con_push, input logic disturba);
    int pos, sp, exp_lat, got_lat;
    sp = modello.size();
    pos = -1;
    for (int i = sp - 1; i >= 0; i--) begin
      if (modello[i] == key) begin pos = i; break; end
    end
    exp_lat = (sp == 0) ? 1 : (pos >= 0) ? (sp - 1 - pos) + 2 : sp + 1;
    got_lat = 99;
    cerca = 1'b1; chiave = key; push = con_push; dato_in = N'($urandom);
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk);
      if (j == 0) begin
        cerca = 1'b0; push = disturba;
        verifica("srch_err_same", 32'(errore), 32'(con_push));
        verifica("srch_busy", 32'(occupato), 32'd1);
        verifica("srch_clr_trov", 32'(trovato), 32'd0);
      end
      if (j == 1) begin
        push = 1'b0;
        verifica("srch_err_busy", 32'(errore), 32'(disturba));
      end
      if (fatto) begin got_lat = j; break; end
    end
    push = 1'b0;
    verifica("srch_latency", 32'(got_lat), 32'(exp_lat));
    verifica("srch_trovato", 32'(trovato), 32'(pos >= 0));
    verifica("srch_indice", 32'(indice), (pos >= 0) ? 32'(pos) : 32'd0);
    @(negedge clk);
    verifica("srch_fatto_pulse", 32'(fatto), 32'd0);
    verifica("srch_trov_held", 32'(trovato), 32'(pos >= 0));
    verifica("srch_idle", 32'(occupato), 32'd0);
    controlla_stato("srch");
  endtask

  initial begin
    logic sticky_fatto;
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; cerca = 1'b0; dato_in = '0; chiave = '0;
    repeat (3) @(negedge clk);
    verifica("rst_dato_out", 32'(dato_out), 32'd0);
    verifica("rst_vuota", 32'(vuota), 32'd1);
    verifica("rst_piena", 32'(piena), 32'd0);
    verifica("rst_occupato", 32'(occupato), 32'd0);
    verifica("rst_fatto", 32'(fatto), 32'd0);
    verifica("rst_trovato", 32'(trovato), 32'd0);
    verifica("rst_indice", 32'(indice), 32'd0);
    verifica("rst_errore", 32'(errore), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op(1, 0, 16'h0011);
    op(1, 0, 16'h0022);
    op(1, 0, 16'h0033);
    ricerca(16'h0033, 0, 0);
    ricerca(16'h0011, 0, 0);
    ricerca(16'h0044, 0, 0);

    // Fill, overflow, drain, underflow
    while (modello.size() < DEPTH) op(1, 0, N'($urandom));
    op(1, 0, 16'hBEEF);
    while (modello.size() > 0) op(0, 1, '0);
    op(0, 1, '0);
    ricerca(16'h1234, 0, 0);
    op(1, 1, 16'h00AA);
    op(1, 1, 16'h00BB);

    op(1, 0, 16'h0011);
    ricerca(16'h0011, 1, 0);
    ricerca(16'h00BB, 0, 1);
    ricerca(16'h0077, 1, 1);

    // Reset in the middle of a scan of a full stack
    while (modello.size() < DEPTH) op(1, 0, 16'h0100 + 16'(modello.size()));
    cerca = 1'b1; chiave = 16'hFFFF;
    @(negedge clk);
    cerca = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    modello.delete();
    verifica("mid_rst_occupato", 32'(occupato), 32'd0);
    verifica("mid_rst_fatto", 32'(fatto), 32'd0);
    verifica("mid_rst_trovato", 32'(trovato), 32'd0);
    verifica("mid_rst_errore", 32'(errore), 32'd0);
    controlla_stato("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    sticky_fatto = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      sticky_fatto |= fatto;
    end
    verifica("mid_rst_no_fatto", 32'(sticky_fatto), 32'd0);
    controlla_stato("post_rst");

    // Random mix; a small value range forces duplicate keys
    for (int it = 0; it < 250; it++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)       op(1, 0, N'($urandom_range(0, 7)));
      else if (sel < 6)  op(0, 1, '0);
      else if (sel < 7)  op(1, 1, N'($urandom_range(0, 7)));
      else               ricerca(N'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
                                 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
